lcd_feed_ctrl: RTL and testbench
================================

LCD_FEED_CTRL -- requirements
Module: lcd_feed_ctrl

Interface
REQ-001 Parameter INIT_CYCLES, default 32, meaning idle cycles after the display-driver reset pulse before the first write.
REQ-002 Parameter WRITE_CYCLES, default 96, meaning cycles reserved per 18-bit write: 2 cursor sets plus 18 characters at 4 cycles each, plus margin.
REQ-003 Parameter REFRESH_PERIOD, default 0, meaning IDLE cycles between automatic rewrites; 0 disables refresh.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 valueIn  in  18  processor word to display.
REQ-007 valueValid  in  1  one-cycle strobe qualifying valueIn.
REQ-008 forceRefresh  in  1  one-cycle strobe; rewrite even if unchanged.
REQ-009 dataOut  out  18  word presented to the LCD driver dataIn; held stable from issue until the next issue.
REQ-010 lcdEnable  out  1  one-cycle start strobe to the LCD driver enable.
REQ-011 lcdRst  out  1  one-cycle active-high reset strobe to the LCD driver rst.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 pending  out  1  a captured word awaits issue.

Function
REQ-014 The FSM SHALL have states INIT_PULSE, INIT_WAIT, IDLE, ISSUE and WAIT.
- INIT_PULSE: lcdRst=1 for 1 cycle, then INIT_WAIT.
- INIT_WAIT: counts INIT_CYCLES, then IDLE.
- IDLE: if pending, go to ISSUE.
- ISSUE: 1 cycle, then WAIT.
- WAIT: counts WRITE_CYCLES, then IDLE.
REQ-015 Entering ISSUE SHALL load dataOut and the shadow register (last written word) from pendVal, clear pending, and drive lcdEnable=1 for that cycle only.
REQ-016 A valueValid whose valueIn differs from the shadow SHALL set pending and load pendVal at that edge, in any state.
REQ-017 A valueValid whose valueIn equals the shadow, with forceRefresh low, SHALL NOT change pendVal or pending.
REQ-018 forceRefresh SHALL set pending. pendVal SHALL become valueIn if valueValid is high in the same cycle, otherwise the shadow value.
REQ-019 Captures while pending is set SHALL overwrite pendVal (latest wins); at most one write SHALL be queued.
REQ-020 Latency: valueValid sampled at edge N while in IDLE with pending low -> lcdEnable high in the cycle after edge N+1.
REQ-021 A capture in the same cycle as the WAIT->IDLE transition SHALL be kept and issued from IDLE on the following edge.
REQ-022 lcdEnable SHALL never assert in INIT_PULSE, INIT_WAIT or WAIT.
REQ-023 Consecutive lcdEnable pulses SHALL be separated by at least WRITE_CYCLES+1 cycles.
REQ-024 The refresh counter SHALL run only in IDLE with pending low, SHALL clear on leaving IDLE, and at REFRESH_PERIOD-1 SHALL set pending with pendVal=shadow.
REQ-025 All counters SHALL be 24 bits wide. The INIT and WAIT counters SHALL clear on state entry, and their terminal compare SHALL be count==PARAM-1; a PARAM of 0 SHALL be treated as 1.
REQ-026 busy and pending SHALL be registered outputs.

Reset
REQ-027 While rst=0, all outputs SHALL be 0, the FSM SHALL be held in INIT_PULSE, and all counters, shadow and pendVal SHALL be 0.
REQ-028 On reset, pending SHALL initialise to 1 so the first write after init displays 18 zeros.
REQ-029 rst asserted mid-WAIT or mid-ISSUE SHALL abort immediately without completing the strobe.
REQ-030 After rst deasserts, the full INIT_PULSE/INIT_WAIT sequence SHALL rerun.

Verification (INIT_CYCLES=4, WRITE_CYCLES=8, REFRESH_PERIOD=0 unless stated)
REQ-031 Release rst -> lcdRst high for 1 cycle, then INIT_WAIT for 4 cycles, then lcdEnable with dataOut=18'h00000, then busy low after 8 WAIT cycles.
REQ-032 In IDLE, valueValid with valueIn=18'h2A5A5 -> lcdEnable in the cycle after the next edge with dataOut=18'h2A5A5; a repeat of 18'h2A5A5 -> no lcdEnable; a repeat with forceRefresh -> exactly one lcdEnable.
REQ-033 During WAIT, valueValid 18'h00001, then 18'h00002, then 18'h00003 -> exactly one further write, dataOut=18'h00003, issued the cycle after WAIT ends.
REQ-034 valueValid 18'h3FFFF on the final WAIT cycle -> held, with lcdEnable high in the cycle after the next edge.
REQ-035 rst low for 1 cycle mid-WAIT -> outputs 0 at once; after release, the full init sequence reruns and 18'h00000 is written.
REQ-036 REFRESH_PERIOD=20, no input -> lcdEnable recurs every 30 cycles (1 issue + 8 wait + 1 transition + 20 idle) with an unchanged dataOut.

Source files
------------

// File: rtl/lcd_feed_ctrl_if.sv
// Processor-to-LCD feed bundle: incoming display words and the strobes toward the LCD driver.
// master: valueIn, valueValid, forceRefresh out; dataOut, lcdEnable, lcdRst, busy, pending in.
// slave : mirror of master (the controller side).
interface lcd_feed_if;
  logic [17:0] valueIn;
  logic        valueValid;
  logic        forceRefresh;
  logic [17:0] dataOut;
  logic        lcdEnable;
  logic        lcdRst;
  logic        busy;
  logic        pending;

  modport master (
    output valueIn, valueValid, forceRefresh,
    input  dataOut, lcdEnable, lcdRst, busy, pending
  );

  modport slave (
    input  valueIn, valueValid, forceRefresh,
    output dataOut, lcdEnable, lcdRst, busy, pending
  );
endinterface

// File: rtl/lcd_feed_ctrl.sv
// Sequences an 18-bit LCD driver: reset pulse, init wait, then one write per changed/forced word.
// Ports: clk, rst (async active-low), bus (lcd_feed_if.slave: value capture in, driver strobes out).
// Latency: capture at edge N in idle -> lcdEnable after edge N+1; one word queued, latest wins.
module lcd_feed_ctrl #(
  parameter int unsigned INIT_CYCLES    = 32,
  parameter int unsigned WRITE_CYCLES   = 96,
  parameter int unsigned REFRESH_PERIOD = 0
) (
  input  logic       clk,
  input  logic       rst,
  lcd_feed_if.slave  bus
);

  // A zero-length wait is treated as one cycle.
  localparam logic [23:0] INIT_LAST    = (INIT_CYCLES  == 0) ? 24'd0 : 24'(INIT_CYCLES - 1);
  localparam logic [23:0] WRITE_LAST   = (WRITE_CYCLES == 0) ? 24'd0 : 24'(WRITE_CYCLES - 1);
  localparam bit          REFRESH_EN   = (REFRESH_PERIOD != 0);
  localparam logic [23:0] REFRESH_LAST = REFRESH_EN ? 24'(REFRESH_PERIOD - 1) : 24'd0;

  typedef enum logic [2:0] {
    INIT_PULSE,
    INIT_WAIT,
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q;        // shared INIT_WAIT / WAIT cycle counter
  logic [23:0] rfr_q;        // idle cycles since last write (refresh timer)
  logic        armed_q;      // low for the first cycle after reset release
  logic        pend_q, pend_d;
  logic [17:0] pend_val_q, pend_val_d;
  logic [17:0] shadow_q, shadow_d;
  logic [17:0] data_q;
  logic        busy_q;
  logic        pend_out_q;
  logic        issue_go;
  logic        rfr_hit;
  logic        lcd_en;
  logic        lcd_rst_c;

  // FSM next-state and strobes.
  always_comb begin
    state_d   = state_q;
    lcd_en    = 1'b0;
    lcd_rst_c = 1'b0;
    case (state_q)
      INIT_PULSE: begin
        // Spend the first post-reset cycle settling so the driver reset
        // strobe is never asserted while our own reset is still low.
        if (armed_q) begin
          lcd_rst_c = 1'b1;
          state_d   = INIT_WAIT;
        end
      end
      INIT_WAIT: if (cnt_q == INIT_LAST) state_d = IDLE;
      IDLE:      if (pend_q) state_d = ISSUE;
      ISSUE: begin
        lcd_en  = 1'b1;
        state_d = WAIT;
      end
      WAIT:      if (cnt_q == WRITE_LAST) state_d = IDLE;
      default:   state_d = INIT_PULSE;
    endcase
  end

  assign issue_go = (state_q == IDLE) && pend_q;
  assign rfr_hit  = REFRESH_EN && (state_q == IDLE) && !pend_q && (rfr_q == REFRESH_LAST);

  // Pending word capture. Incoming values compare against the shadow as it
  // will be after this edge, so a word equal to the one being issued now is
  // recognised as a repeat.
  always_comb begin
    shadow_d   = issue_go ? pend_val_q : shadow_q;
    pend_d     = pend_q & ~issue_go;
    pend_val_d = pend_val_q;
    if (rfr_hit) begin
      pend_d     = 1'b1;
      pend_val_d = shadow_q;
    end
    if (bus.forceRefresh) begin
      pend_d     = 1'b1;
      pend_val_d = bus.valueValid ? bus.valueIn : shadow_d;
    end else if (bus.valueValid && (bus.valueIn != shadow_d)) begin
      pend_d     = 1'b1;
      pend_val_d = bus.valueIn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT_PULSE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      rfr_q <= '0;
    end else begin
      if (state_d != state_q)
        cnt_q <= '0;
      else if ((state_q == INIT_WAIT) || (state_q == WAIT))
        cnt_q <= cnt_q + 24'd1;

      // Timer only runs while idle with nothing queued; it parks on the hit
      // cycle and clears once the resulting write leaves IDLE.
      if (REFRESH_EN && (state_q == IDLE) && !pend_q) begin
        if (!rfr_hit) rfr_q <= rfr_q + 24'd1;
      end else begin
        rfr_q <= '0;
      end
    end
  end

  // pend_q comes out of reset set, so the first write after init blanks the
  // display to zeros; the visible pending flag stays 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= 1'b1;
      pend_val_q <= '0;
      shadow_q   <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      pend_out_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      shadow_q   <= shadow_d;
      if (issue_go) data_q <= pend_val_q;
      busy_q     <= (state_d != IDLE);
      pend_out_q <= pend_d;
    end
  end

  assign bus.dataOut   = data_q;
  assign bus.lcdEnable = lcd_en;
  assign bus.lcdRst    = lcd_rst_c;
  assign bus.busy      = busy_q;
  assign bus.pending   = pend_out_q;

endmodule

// File: tb/tb_lcd_feed_ctrl.sv
// Directed bench for lcd_feed_ctrl: one instance without refresh, one with REFRESH_PERIOD=20.
// Inputs driven 1 time unit after each rising edge; outputs observed at the same point.
module tb_lcd_feed_ctrl;
  logic clk;
  logic rst0;
  logic rst1;
  int   vectors;
  int   miscompares;
  int   cyc;
  int   pulses;

  lcd_feed_if b0();
  lcd_feed_if b1();

  lcd_feed_ctrl #(.INIT_CYCLES(4), .WRITE_CYCLES(8), .REFRESH_PERIOD(0)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (b0.slave)
  );

  lcd_feed_ctrl #(.INIT_CYCLES(4), .WRITE_CYCLES(8), .REFRESH_PERIOD(20)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tick until the selected instance raises lcdEnable, at most max times.
  task automatic wait_en(input int sel, input int max, output int n);
    logic en;
    n = 0;
    do begin
      tick();
      n++;
      en = (sel == 0) ? b0.lcdEnable : b1.lcdEnable;
    end while ((n < max) && !en);
  endtask

  // Tick n times on instance 0, counting cycles with lcdEnable high.
  task automatic count_en(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (b0.lcdEnable) p++;
    end
  endtask

  task automatic send(input logic [17:0] v, input logic force_r);
    b0.valueIn      = v;
    b0.valueValid   = 1'b1;
    b0.forceRefresh = force_r;
    tick();
    b0.valueValid   = 1'b0;
    b0.forceRefresh = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst0 = 1'b0;
    rst1 = 1'b0;
    b0.valueIn = '0; b0.valueValid = 1'b0; b0.forceRefresh = 1'b0;
    b1.valueIn = '0; b1.valueValid = 1'b0; b1.forceRefresh = 1'b0;

    // Reset state.
    tick(); tick();
    chk("rst_data",    b0.dataOut,   0);
    chk("rst_en",      b0.lcdEnable, 0);
    chk("rst_lcdrst",  b0.lcdRst,    0);
    chk("rst_busy",    b0.busy,      0);
    chk("rst_pending", b0.pending,   0);
    chk("rst1_lcdrst", b1.lcdRst,    0);

    // Init sequence and blank write.
    rst0 = 1'b1;
    tick();
    chk("init_lcdrst", b0.lcdRst,  1);
    chk("init_busy",   b0.busy,    1);
    chk("init_pend",   b0.pending, 1);
    tick();
    chk("initw_lcdrst", b0.lcdRst, 0);
    count_en(3, pulses);
    chk("initw_noen", pulses, 0);
    chk("initw_busy", b0.busy, 1);
    tick();
    chk("idle0_busy", b0.busy, 0);
    chk("idle0_en",   b0.lcdEnable, 0);
    tick();
    chk("blank_en",   b0.lcdEnable, 1);
    chk("blank_data", b0.dataOut,   18'h00000);
    chk("blank_pend", b0.pending,   0);
    count_en(8, pulses);
    chk("wait_noen", pulses, 0);
    chk("wait_busy", b0.busy, 1);
    tick();
    chk("idle1_busy", b0.busy, 0);

    // New word, repeat, forced repeat.
    send(18'h2A5A5, 1'b0);
    chk("cap_pend", b0.pending,   1);
    chk("cap_en",   b0.lcdEnable, 0);
    tick();
    chk("w1_en",   b0.lcdEnable, 1);
    chk("w1_data", b0.dataOut,   18'h2A5A5);
    count_en(9, pulses);
    chk("w1_busy", b0.busy, 0);
    send(18'h2A5A5, 1'b0);
    chk("rep_pend", b0.pending, 0);
    count_en(12, pulses);
    chk("rep_noen", pulses, 0);
    send(18'h2A5A5, 1'b1);
    chk("frc_pend", b0.pending, 1);
    count_en(11, pulses);
    chk("frc_one",  pulses, 1);
    chk("frc_data", b0.dataOut, 18'h2A5A5);

    // Three captures during WAIT collapse into one write of the last.
    send(18'h00015, 1'b0);
    tick();
    chk("w2_en", b0.lcdEnable, 1);
    tick();
    send(18'h00001, 1'b0);
    send(18'h00002, 1'b0);
    send(18'h00003, 1'b0);
    wait_en(0, 10, cyc);
    chk("coal_lat",  cyc, 6);
    chk("coal_data", b0.dataOut, 18'h00003);
    count_en(12, pulses);
    chk("coal_one", pulses, 0);

    // Capture on the final WAIT cycle.
    send(18'h00007, 1'b0);
    tick();
    chk("w3_en", b0.lcdEnable, 1);
    count_en(8, pulses);
    chk("last_busy", b0.busy, 1);
    send(18'h3FFFF, 1'b0);
    chk("edge_en",   b0.lcdEnable, 0);
    chk("edge_pend", b0.pending,   1);
    chk("edge_busy", b0.busy,      0);
    tick();
    chk("edge_w_en",   b0.lcdEnable, 1);
    chk("edge_w_data", b0.dataOut,   18'h3FFFF);

    // Reset mid-WAIT.
    tick(); tick(); tick();
    rst0 = 1'b0;
    #1;
    chk("abort_data", b0.dataOut,   0);
    chk("abort_en",   b0.lcdEnable, 0);
    chk("abort_busy", b0.busy,      0);
    chk("abort_pend", b0.pending,   0);
    tick();
    rst0 = 1'b1;
    tick();
    chk("rerun_lcdrst", b0.lcdRst, 1);
    wait_en(0, 10, cyc);
    chk("rerun_lat",  cyc, 6);
    chk("rerun_data", b0.dataOut, 18'h00000);

    // Automatic refresh on the second instance.
    rst1 = 1'b1;
    tick();
    chk("r_lcdrst", b1.lcdRst, 1);
    wait_en(1, 10, cyc);
    chk("r_first", cyc, 6);
    wait_en(1, 40, cyc);
    chk("r_period1", cyc, 30);
    chk("r_data1",   b1.dataOut, 18'h00000);
    wait_en(1, 40, cyc);
    chk("r_period2", cyc, 30);
    chk("r_data2",   b1.dataOut, 18'h00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
